// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Purpose  : Shared types, constants and helpers for the iterative RV32M
//            multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  // funct3 encodings of the M-extension operations
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_t;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam int          ITER    = 32;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  // Two's-complement negate
  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_iter
// Purpose  : Iterative RV32M multiply/divide unit. Latches operands, runs a
//            32-step shift-add multiply or restoring divide on magnitudes,
//            fixes signs / special cases, then writes the register file once.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic            we3,
  output logic [4:0]      a3,
  output logic [XLEN-1:0] wd3
);

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] a_q, a_d, b_q, b_d;        // operands as latched
  logic [31:0] opa_q, opa_d, opb_q, opb_d; // working magnitudes
  logic        sa_q, sa_d, sb_q, sb_d;    // operand signs
  logic        dz_q, dz_d, ovf_q, ovf_d;  // special-case flags
  logic [63:0] acc_q, acc_d;              // product, or {remainder, quotient}
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] res_q, res_d;

  logic        busy_q, busy_d, done_q, done_d, we3_q, we3_d;
  logic [4:0]  a3_q, a3_d;
  logic [31:0] wd3_q, wd3_d;

  // Datapath helpers
  logic        is_div, sgn_a, sgn_b, qbit;
  logic [32:0] mul_sum, div_pr;
  logic [33:0] div_diff;
  logic [63:0] prod_s;
  logic [31:0] quo_s, rem_s;
  logic        unused_bits;

  assign is_div = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign sgn_a  = op_q inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign sgn_b  = op_q inside {OP_MULH, OP_DIV, OP_REM};

  // Multiply step: add multiplicand into the upper half, then shift right
  assign mul_sum = {1'b0, acc_q[63:32]} + (opb_q[0] ? {1'b0, opa_q} : 33'd0);

  // Divide step: bring in next dividend bit, trial-subtract the divisor
  assign div_pr   = {acc_q[63:32], opa_q[31]};
  assign div_diff = {1'b0, div_pr} - {2'b00, opb_q};
  assign qbit     = ~div_diff[33];
  // A successful subtraction always leaves a remainder below 2^32
  assign unused_bits = div_diff[32];

  assign prod_s = (sa_q ^ sb_q) ? (~acc_q + 64'd1) : acc_q;
  assign quo_s  = (sa_q ^ sb_q) ? neg32(acc_q[31:0]) : acc_q[31:0];
  assign rem_s  = sa_q ? neg32(acc_q[63:32]) : acc_q[63:32];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_PREP;
      S_PREP: state_d = S_RUN;
      S_RUN:  if (cnt_q == 5'(ITER - 1)) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    op_d  = op_q;   rd_d  = rd_q;  a_d   = a_q;   b_d   = b_q;
    opa_d = opa_q;  opb_d = opb_q; sa_d  = sa_q;  sb_d  = sb_q;
    dz_d  = dz_q;   ovf_d = ovf_q; acc_d = acc_q; cnt_d = cnt_q;
    res_d = res_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d = op_t'(funct3);
          rd_d = rd;
          a_d  = a[31:0];
          b_d  = b[31:0];
        end
      end
      S_PREP: begin
        sa_d  = sgn_a & a_q[31];
        sb_d  = sgn_b & b_q[31];
        opa_d = sa_d ? neg32(a_q) : a_q;
        opb_d = sb_d ? neg32(b_q) : b_q;
        acc_d = 64'd0;
        cnt_d = 5'd0;
        dz_d  = (b_q == 32'd0);
        ovf_d = (op_q inside {OP_DIV, OP_REM}) && (a_q == INT_MIN) &&
                (b_q == 32'hFFFF_FFFF);
      end
      S_RUN: begin
        cnt_d = cnt_q + 5'd1;
        if (is_div) begin
          acc_d = {(qbit ? div_diff[31:0] : div_pr[31:0]), acc_q[30:0], qbit};
          opa_d = {opa_q[30:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
          opb_d = {1'b0, opb_q[31:1]};
        end
      end
      S_FIX: begin
        case (op_q)
          OP_MUL:                       res_d = prod_s[31:0];
          OP_MULH, OP_MULHSU, OP_MULHU: res_d = prod_s[63:32];
          OP_DIV, OP_DIVU:              res_d = dz_q ? 32'hFFFF_FFFF :
                                                ovf_q ? INT_MIN : quo_s;
          default:                      res_d = dz_q ? a_q :
                                                ovf_q ? 32'd0 : rem_s;
        endcase
      end
      default: ;
    endcase

    done_d = (state_q == S_DONE);
    we3_d  = done_d && (rd_q != 5'd0);
    a3_d   = done_d ? rd_q  : a3_q;
    wd3_d  = done_d ? res_q : wd3_q;
    busy_d = (state_d != S_IDLE) || done_d;
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= OP_MUL; rd_q  <= '0; a_q   <= '0; b_q   <= '0;
      opa_q <= '0;     opb_q <= '0; sa_q  <= 1'b0; sb_q <= 1'b0;
      dz_q  <= 1'b0;   ovf_q <= 1'b0; acc_q <= '0; cnt_q <= '0;
      res_q <= '0;
      busy_q <= 1'b0; done_q <= 1'b0; we3_q <= 1'b0;
      a3_q   <= '0;   wd3_q  <= '0;
    end else begin
      op_q  <= op_d;  rd_q  <= rd_d;  a_q   <= a_d;   b_q   <= b_d;
      opa_q <= opa_d; opb_q <= opb_d; sa_q  <= sa_d;  sb_q  <= sb_d;
      dz_q  <= dz_d;  ovf_q <= ovf_d; acc_q <= acc_d; cnt_q <= cnt_d;
      res_q <= res_d;
      busy_q <= busy_d; done_q <= done_d; we3_q <= we3_d;
      a3_q   <= a3_d;   wd3_q  <= wd3_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign we3  = we3_q;
  assign a3   = a3_q;
  assign wd3  = XLEN'(wd3_q);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_iter
// Purpose  : Self-checking bench for muldiv_iter: vector table, random ops
//            against a behavioural model, and multi-cycle corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_iter;

  localparam int LAT = 35;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [4:0]  rd = '0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, we3;
  logic [4:0]  a3;
  logic [31:0] wd3;

  muldiv_iter #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .rd(rd),
    .a(a), .b(b), .busy(busy), .done(done), .we3(we3), .a3(a3), .wd3(wd3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_fail = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    int          t0;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [2:0]  f;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model built on the simulator's own arithmetic
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] x,
                                         input logic [31:0] y);
    logic signed [63:0] xs, ys, ps;
    logic        [63:0] pu;
    logic signed [31:0] xs32, ys32;
    logic        [31:0] r;
    xs = {{32{x[31]}}, x};
    ys = {{32{y[31]}}, y};
    xs32 = x;
    ys32 = y;
    case (f)
      3'd0: r = x * y;
      3'd1: begin ps = xs * ys; r = ps[63:32]; end
      3'd2: begin ps = xs * $signed({32'd0, y}); r = ps[63:32]; end
      3'd3: begin pu = {32'd0, x} * {32'd0, y}; r = pu[63:32]; end
      3'd4: if (y == 0) r = 32'hFFFF_FFFF;
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h8000_0000;
            else r = xs32 / ys32;
      3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: if (y == 0) r = x;
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'd0;
            else r = xs32 % ys32;
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Drive one request and record what the write-back must look like
  task automatic issue(input logic [2:0] f, input logic [4:0] r, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] e);
    exp_t it;
    @(negedge clk);
    funct3 = f; rd = r; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    it.rd = r; it.data = e; it.we = (r != 5'd0); it.t0 = cyc;
    sb.push_back(it);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    funct3 = 3'($urandom); rd = 5'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) break;
    end
    if (k == 100) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_idle: timeout with %0d results outstanding, busy=%0b", sb.size(), busy);
      sb.delete();
    end
  endtask

  // Scoreboard monitor: every completion must match the oldest request
  initial begin
    logic done_seen;
    exp_t it;
    done_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        done_seen = 1'b0;
      end else begin
        if (done_seen) check("busy_after_done", {31'd0, busy}, 32'd0);
        done_seen = 1'b0;
        if (we3 && !done) begin
          n_cmp++;
          n_fail++;
          $display("FAIL we3_without_done: we3=1 done=0 at cycle %0d", cyc);
        end
        if (done) begin
          done_seen = 1'b1;
          n_cmp++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_done: a3=%0d wd3=0x%08h we3=%0b with nothing pending",
                     a3, wd3, we3);
          end else begin
            it = sb.pop_front();
            check("wd3", wd3, it.data);
            check("a3", {27'd0, a3}, {27'd0, it.rd});
            check("we3", {31'd0, we3}, {31'd0, it.we});
            check("latency", 32'(cyc - it.t0), 32'(LAT));
          end
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{3'b000, 5'd1,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{3'b001, 5'd2,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{3'b011, 5'd3,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3]  = '{3'b010, 5'd4,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4]  = '{3'b100, 5'd5,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
    vecs[5]  = '{3'b110, 5'd6,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[6]  = '{3'b101, 5'd7,  32'h0000_0007, 32'h0000_0002, 32'h0000_0003};
    vecs[7]  = '{3'b111, 5'd8,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001};
    vecs[8]  = '{3'b101, 5'd9,  32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[9]  = '{3'b110, 5'd10, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005};
    vecs[10] = '{3'b100, 5'd11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[11] = '{3'b110, 5'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[12] = '{3'b011, 5'd13, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001};
    vecs[13] = '{3'b000, 5'd14, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
    vecs[14] = '{3'b100, 5'd15, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2};
    vecs[15] = '{3'b110, 5'd16, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFFE};
    vecs[16] = '{3'b101, 5'd17, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF};
    vecs[17] = '{3'b111, 5'd18, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F};
    vecs[18] = '{3'b100, 5'd19, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[19] = '{3'b111, 5'd0,  32'h0000_0009, 32'h0000_0000, 32'h0000_0009};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_we3",  {31'd0, we3},  32'd0);
    check("rst_a3",   {27'd0, a3},   32'd0);
    check("rst_wd3",  wd3,           32'd0);
    reset = 1'b0;

    // Directed vector table
    for (int i = 0; i < 20; i++) begin
      issue(vecs[i].f, vecs[i].rd, vecs[i].a, vecs[i].b, vecs[i].exp);
      wait_idle();
    end

    // start while busy is ignored; the first request's result is written
    issue(3'b101, 5'd5, 32'd7, 32'd2, 32'd3);
    repeat (5) @(negedge clk);
    funct3 = 3'b000; rd = 5'd6; a = 32'd3; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // rd = 0: completion pulse without a register write
    issue(3'b000, 5'd0, 32'd6, 32'd7, 32'd42);
    wait_idle();

    // Reset 10 cycles into a divide aborts it with no write-back
    issue(3'b100, 5'd9, 32'd100, 32'd7, 32'd14);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_we3",  {31'd0, we3},  32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    issue(3'b000, 5'd7, 32'd3, 32'd4, 32'd12);
    wait_idle();

    // Random operations with corner-biased operands
    for (int i = 0; i < 24; i++) begin
      logic [2:0]  f;
      logic [31:0] x, y;
      f = 3'($urandom_range(0, 7));
      x = pick();
      y = pick();
      issue(f, 5'($urandom_range(0, 31)), x, y, ref_op(f, x, y));
      wait_idle();
    end

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
